berger_scrub_reader: RTL

- Sequential read-side scrubber for the Berger-coded 12-bit memory.
- On `start`, walks every address 0..DEPTH-1 with one read per cycle and recomputes the Berger check of each returned codeword.
- Reports per-word error pulses, a saturating error count and the first failing address.
- Sits beside the host port of the Berger memory; it is the checking/reading end of the encode-store path.

---
 rtl/berger_pkg.sv | 28 ++
 rtl/berger_word_check.sv | 17 +
 rtl/berger_scrub_reader.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/berger_pkg.sv
// Shared Berger-code definitions: codeword geometry, scrubber FSM states
// and the zero-count helper used to recompute check fields.
package berger_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CHK_W  = 4;
  localparam int unsigned CW_W   = 12;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    DONE
  } scrub_state_e;

  function automatic logic [CHK_W-1:0] count_zeros(input logic [DATA_W-1:0] data);
    logic [CHK_W-1:0]  n;
    logic [DATA_W-1:0] d;
    n = '0;
    d = data;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      n = n + {{(CHK_W-1){1'b0}}, ~d[0]};
      d = d >> 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/berger_word_check.sv
// Combinational Berger check of one 12-bit codeword: recomputes the zero
// count of the data field and flags any difference from the stored check.
module berger_word_check
  import berger_pkg::*;
(
  input  logic [11:0] codeword,
  output logic        err,
  output logic [3:0]  check
);

  // Stored check values 9..15 can never match a count of at most 8.
  always_comb begin
    check = count_zeros(codeword[CW_W-1:CHK_W]);
    err   = (check != codeword[CHK_W-1:0]);
  end

endmodule

// File: rtl/berger_scrub_reader.sv
// Read-side scrubber: scans addresses 0..DEPTH-1, checks each returned
// Berger codeword and reports errors. Optional macro BERGER_SCRUB_HALT_EN.
module berger_scrub_reader
  import berger_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [11:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err_pulse,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  err_count,
  output logic              first_err_valid,
  output logic [ADDR_W-1:0] first_err_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  scrub_state_e      state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              chk_vld_q, chk_vld_d;
  logic [ADDR_W-1:0] chk_addr_q, chk_addr_d;
  logic              err_pulse_q, err_pulse_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [CNT_W-1:0]  err_count_q, err_count_d;
  logic              first_vld_q, first_vld_d;
  logic [ADDR_W-1:0] first_addr_q, first_addr_d;

  logic              word_err;
  logic [3:0]        chk_unused;
  logic              word_bad;
  logic              halt_req;

  berger_word_check u_check (
    .codeword (mem_rdata),
    .err      (word_err),
    .check    (chk_unused)
  );

  assign word_bad = chk_vld_q & word_err;

`ifdef BERGER_SCRUB_HALT_EN
  assign halt_req = word_bad;
`else
  assign halt_req = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    rd_en_d      = 1'b0;
    addr_d       = '0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    chk_vld_d    = rd_en_q;
    chk_addr_d   = addr_q;
    err_pulse_d  = word_bad;
    err_addr_d   = word_bad ? chk_addr_q : '0;
    err_count_d  = err_count_q;
    first_vld_d  = first_vld_q;
    first_addr_d = first_addr_q;

    if (word_bad) begin
      if (err_count_q != CNT_MAX) err_count_d = err_count_q + 1'b1;
      if (!first_vld_q) begin
        first_vld_d  = 1'b1;
        first_addr_d = chk_addr_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SCAN;
          rd_en_d      = 1'b1;
          busy_d       = 1'b1;
          err_count_d  = '0;
          first_vld_d  = 1'b0;
          first_addr_d = '0;
        end
      end
      // The read issued this cycle is still checked in DRAIN, even on halt.
      SCAN: begin
        if (addr_q == LAST_ADDR || halt_req) begin
          state_d = DRAIN;
        end else begin
          rd_en_d = 1'b1;
          addr_d  = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        state_d = DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      chk_vld_q    <= 1'b0;
      chk_addr_q   <= '0;
      err_pulse_q  <= 1'b0;
      err_addr_q   <= '0;
      err_count_q  <= '0;
      first_vld_q  <= 1'b0;
      first_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      chk_vld_q    <= chk_vld_d;
      chk_addr_q   <= chk_addr_d;
      err_pulse_q  <= err_pulse_d;
      err_addr_q   <= err_addr_d;
      err_count_q  <= err_count_d;
      first_vld_q  <= first_vld_d;
      first_addr_q <= first_addr_d;
    end
  end

  assign mem_rd_en       = rd_en_q;
  assign mem_addr        = addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign err_pulse       = err_pulse_q;
  assign err_addr        = err_addr_q;
  assign err_count       = err_count_q;
  assign first_err_valid = first_vld_q;
  assign first_err_addr  = first_addr_q;

endmodule
